galois_lfsr_gen: RTL and testbench

- Parametrised Galois LFSR, next generation of the fixed 5-bit scrambler/PRBS source.
- Adds configurable width, tap mask and seed, plus multi-step advance per clock.
- Adds runtime seed load with all-zero lock-up protection, a serial bit output, and period measurement.
- Used as a PRBS generator in datapath test sources and as a pseudo-random source for arbiters.

---
 rtl/galois_lfsr_gen.sv | 92 +++++++++
 tb/tb_galois_lfsr_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/galois_lfsr_gen.sv
// Parametrised Galois LFSR with multi-step advance, runtime seed load with zero-lock protection,
// serial feedback-bit output and period measurement against an anchor state.
module galois_lfsr_gen #(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state,
  output logic [STEPS-1:0] bits_o,
  output logic             load_err,
  output logic             period_hit,
  output logic [WIDTH-1:0] period_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] anchor_q;
  logic [WIDTH-1:0] cnt_q;
  logic [STEPS-1:0] bits_q;
  logic             load_err_q;
  logic             hit_q;
  logic [WIDTH-1:0] period_q;

  logic [WIDTH-1:0] adv_state;
  logic [STEPS-1:0] adv_bits;
  logic [WIDTH-1:0] cnt_sum;

  // Unrolled chain of STEPS single Galois steps; bit k records the feedback of step k.
  always_comb begin
    adv_state = state_q;
    adv_bits  = '0;
    for (int k = 0; k < STEPS; k++) begin
      adv_bits[k] = adv_state[0];
      adv_state   = (adv_state >> 1) ^ (TAPS & {WIDTH{adv_state[0]}});
    end
  end

  assign cnt_sum = cnt_q + WIDTH'(STEPS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= SEED;
      anchor_q   <= SEED;
      cnt_q      <= '0;
      bits_q     <= '0;
      load_err_q <= 1'b0;
      hit_q      <= 1'b0;
      period_q   <= '0;
    end else if (load) begin
      // A zero seed would lock the register up, so fall back to SEED and flag it.
      if (seed_i == '0) begin
        state_q    <= SEED;
        anchor_q   <= SEED;
        load_err_q <= 1'b1;
      end else begin
        state_q    <= seed_i;
        anchor_q   <= seed_i;
        load_err_q <= 1'b0;
      end
      cnt_q  <= '0;
      bits_q <= '0;
      hit_q  <= 1'b0;
    end else if (en) begin
      state_q    <= adv_state;
      bits_q     <= adv_bits;
      load_err_q <= 1'b0;
      if (adv_state == anchor_q) begin
        hit_q    <= 1'b1;
        period_q <= cnt_sum;
        cnt_q    <= '0;
      end else begin
        hit_q <= 1'b0;
        cnt_q <= cnt_sum;
      end
    end else begin
      load_err_q <= 1'b0;
      hit_q      <= 1'b0;
    end
  end

  assign state      = state_q;
  assign bits_o     = bits_q;
  assign load_err   = load_err_q;
  assign period_hit = hit_q;
  assign period_o   = period_q;

endmodule

// File: tb/tb_galois_lfsr_gen.sv
// Bench for galois_lfsr_gen: three instances (default, STEPS=3, 16-bit) checked every cycle
// against a position-in-sequence model of the LFSR orbit.
module tb_galois_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b0, en0 = 1'b0, load0 = 1'b0;
  logic [4:0] seed0 = '0, state0, per0;
  logic [0:0] bits0;
  logic       lerr0, hit0;

  logic       rst1 = 1'b0, en1 = 1'b0, load1 = 1'b0;
  logic [4:0] seed1 = '0, state1, per1;
  logic [2:0] bits1;
  logic       lerr1, hit1;

  logic        rst2 = 1'b0, en2 = 1'b0, load2 = 1'b0;
  logic [15:0] seed2 = '0, state2, per2;
  logic [0:0]  bits2;
  logic        lerr2, hit2;

  galois_lfsr_gen u_dut0 (
    .clk(clk), .rst(rst0), .en(en0), .load(load0), .seed_i(seed0), .state(state0),
    .bits_o(bits0), .load_err(lerr0), .period_hit(hit0), .period_o(per0)
  );

  galois_lfsr_gen #(.STEPS(3)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .load(load1), .seed_i(seed1), .state(state1),
    .bits_o(bits1), .load_err(lerr1), .period_hit(hit1), .period_o(per1)
  );

  galois_lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2), .load(load2), .seed_i(seed2), .state(state2),
    .bits_o(bits2), .load_err(lerr2), .period_hit(hit2), .period_o(per2)
  );

  // Model: the full orbit of each tap set is listed once; the LFSR is then a position on it.
  typedef struct {
    int steps; int tid; int seed; int mask;
    int pos; int anchor; int cnt; int bits; int lerr; int hit; int period; bit valid;
  } mdl_t;

  mdl_t m[3];
  int   seq[2][$];
  int   idx[2][65536];
  int   nerr = 0;
  int   nchk = 0;

  function automatic int lfsr_step(int s, int taps);
    if ((s & 1) != 0) return (s >> 1) ^ taps;
    return s >> 1;
  endfunction

  task automatic build(int t, int seed, int taps);
    int s;
    s = seed;
    do begin
      idx[t][s] = seq[t].size();
      seq[t].push_back(s);
      s = lfsr_step(s, taps);
    end while (s != seed && seq[t].size() < 70000);
  endtask

  function automatic void mdl_apply(int d, bit r, bit ld, int sd, bit e);
    int p;
    int t;
    t = m[d].tid;
    p = seq[t].size();
    if (!r) begin
      m[d].pos = idx[t][m[d].seed]; m[d].anchor = m[d].pos; m[d].cnt = 0; m[d].bits = 0;
      m[d].lerr = 0; m[d].hit = 0; m[d].period = 0; m[d].valid = 1'b1;
    end else if (ld) begin
      m[d].lerr = (sd == 0) ? 1 : 0;
      m[d].pos  = idx[t][(sd == 0) ? m[d].seed : sd];
      m[d].anchor = m[d].pos; m[d].cnt = 0; m[d].bits = 0; m[d].hit = 0;
    end else if (e) begin
      m[d].bits = 0;
      for (int k = 0; k < m[d].steps; k++)
        m[d].bits |= (seq[t][(m[d].pos + k) % p] & 1) << k;
      m[d].pos  = (m[d].pos + m[d].steps) % p;
      m[d].lerr = 0;
      if (m[d].pos == m[d].anchor) begin
        m[d].hit = 1; m[d].period = (m[d].cnt + m[d].steps) & m[d].mask; m[d].cnt = 0;
      end else begin
        m[d].hit = 0; m[d].cnt = (m[d].cnt + m[d].steps) & m[d].mask;
      end
    end else begin
      m[d].lerr = 0; m[d].hit = 0;
    end
  endfunction

  task automatic check(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int d, string tag, int st, int b, int le, int h, int p);
    if (!m[d].valid) return;
    check({tag, ".state"}, st, seq[m[d].tid][m[d].pos]);
    check({tag, ".bits"}, b, m[d].bits);
    check({tag, ".load_err"}, le, m[d].lerr);
    check({tag, ".period_hit"}, h, m[d].hit);
    check({tag, ".period_o"}, p, m[d].period);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    mdl_apply(0, rst0, load0, int'(seed0), en0);
    mdl_apply(1, rst1, load1, int'(seed1), en1);
    mdl_apply(2, rst2, load2, int'(seed2), en2);
  end

  always @(negedge clk) begin
    cmp(0, "d0", int'(state0), int'(bits0), int'(lerr0), int'(hit0), int'(per0));
    cmp(1, "d1", int'(state1), int'(bits1), int'(lerr1), int'(hit1), int'(per1));
    cmp(2, "d2", int'(state2), int'(bits2), int'(lerr2), int'(hit2), int'(per2));
  end

  initial begin
    build(0, 1, 'h14);
    build(1, 'hACE1, 'hB400);
    m[0] = '{steps: 1, tid: 0, seed: 1, mask: 31, default: 0};
    m[1] = '{steps: 3, tid: 0, seed: 1, mask: 31, default: 0};
    m[2] = '{steps: 1, tid: 1, seed: 'hACE1, mask: 'hFFFF, default: 0};
    check("model.len5", seq[0].size(), 31);
    check("model.len16", seq[1].size(), 65535);
    check("model.seq5_1", seq[0][1], 'h14);
    check("model.seq5_4", seq[0][4], 'h16);

    fork
      begin : dut0_stim
        int  exp_s[4];
        int  exp_b[4];
        int  rep;
        bit  seen[32];
        logic [4:0] save_s;
        exp_s = '{'h14, 'h0A, 'h05, 'h16};
        exp_b = '{1, 0, 0, 1};
        rep = 0;
        seen = '{default: 1'b0};
        cyc();
        rst0 = 1'b1;
        check("d0.reset_state", int'(state0), 1);
        check("d0.reset_period", int'(per0), 0);
        seen[1] = 1'b1;
        en0 = 1'b1;
        for (int i = 1; i <= 31; i++) begin
          cyc();
          if (i <= 4) begin
            check("d0.lit_state", int'(state0), exp_s[i-1]);
            check("d0.lit_bits", int'(bits0), exp_b[i-1]);
          end
          if (i < 31) begin
            if (seen[state0] || state0 == 5'd0) rep++;
            seen[state0] = 1'b1;
            if (hit0) rep++;
          end
        end
        check("d0.first_hit", int'(hit0), 1);
        check("d0.first_period", int'(per0), 31);
        check("d0.first_hit_state", int'(state0), 1);
        check("d0.repeats_in_period", rep, 0);
        repeat (31) cyc();
        check("d0.second_hit", int'(hit0), 1);
        // Zero seed load falls back to SEED.
        load0 = 1'b1; seed0 = 5'd0;
        cyc();
        check("d0.zero_load_state", int'(state0), 1);
        check("d0.zero_load_err", int'(lerr0), 1);
        load0 = 1'b0; en0 = 1'b0;
        cyc();
        check("d0.load_err_pulse", int'(lerr0), 0);
        load0 = 1'b1; seed0 = 5'h0A; en0 = 1'b1;
        cyc();
        check("d0.seed_load_state", int'(state0), 'h0A);
        check("d0.seed_load_err", int'(lerr0), 0);
        load0 = 1'b0;
        repeat (30) cyc();
        check("d0.no_early_hit", int'(hit0), 0);
        cyc();
        check("d0.reload_hit", int'(hit0), 1);
        check("d0.reload_period", int'(per0), 31);
        check("d0.reload_hit_state", int'(state0), 'h0A);
        repeat (3) cyc();
        en0 = 1'b0;
        cyc();
        save_s = state0;
        for (int i = 0; i < 10; i++) begin
          cyc();
          check("d0.hold_state", int'(state0), int'(save_s));
          check("d0.hold_hit", int'(hit0), 0);
        end
        en0 = 1'b1;
        cyc();
        rst0 = 1'b0;
        cyc();
        check("d0.midreset_state", int'(state0), 1);
        check("d0.midreset_period", int'(per0), 0);
        load0 = 1'b1; seed0 = 5'h0A;
        cyc();
        check("d0.reset_beats_load", int'(state0), 1);
        check("d0.reset_beats_load_err", int'(lerr0), 0);
        rst0 = 1'b1; load0 = 1'b0;
        repeat (2000) begin
          en0   = ($urandom_range(0, 9) < 7);
          load0 = ($urandom_range(0, 19) == 0);
          seed0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
          rst0  = ($urandom_range(0, 99) != 0);
          cyc();
        end
        rst0 = 1'b1; load0 = 1'b0; en0 = 1'b0;
      end
      begin : dut1_stim
        cyc();
        rst1 = 1'b1; en1 = 1'b1;
        cyc();
        check("d1.step3_state", int'(state1), 'h05);
        check("d1.step3_bits", int'(bits1), 1);
        repeat (29) cyc();
        check("d1.no_early_hit", int'(hit1), 0);
        cyc();
        check("d1.hit", int'(hit1), 1);
        check("d1.period", int'(per1), 93 % 32);
        check("d1.hit_state", int'(state1), 1);
        repeat (500) begin
          en1   = ($urandom_range(0, 9) < 8);
          load1 = ($urandom_range(0, 29) == 0);
          seed1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
          rst1  = ($urandom_range(0, 99) != 0);
          cyc();
        end
        rst1 = 1'b1; load1 = 1'b0; en1 = 1'b0;
      end
      begin : dut2_stim
        cyc();
        rst2 = 1'b1; en2 = 1'b1;
        check("d2.reset_state", int'(state2), 'hACE1);
        repeat (65534) cyc();
        check("d2.no_early_hit", int'(hit2), 0);
        cyc();
        check("d2.hit", int'(hit2), 1);
        check("d2.period", int'(per2), 'hFFFF);
        check("d2.hit_state", int'(state2), 'hACE1);
        en2 = 1'b0;
      end
    join
    cyc();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
